// File: rtl/qerv_lsbuf_pkg.sv
// Shared encodings for the serial load/store/shift buffer.
package qerv_lsbuf_pkg;

  typedef enum logic [1:0] {
    OP_STORE = 2'b00,
    OP_LOAD  = 2'b01,
    OP_SHL   = 2'b10,
    OP_SHR   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_BUS   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // Size 11 aliases word, so anything that is not byte/half needs lsb == 0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lsb[0];
      default: return lsb != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/qerv_lsbuf_if.sv
// Request, serial data and memory bus signals of the load/store buffer.
interface qerv_lsbuf_if #(
  parameter int W = 1
);
  logic          i_start;
  logic [1:0]    i_op;
  logic [1:0]    i_size;
  logic          i_signed;
  logic [1:0]    i_lsb;
  logic [4:0]    i_shamt;
  logic [W-1:0]  i_d;
  logic [W-1:0]  o_q;
  logic          o_q_vld;
  logic          o_busy;
  logic          o_done;
  logic          o_misalign;
  logic          o_bus_cyc;
  logic          i_bus_ack;
  logic [31:0]   o_bus_dat;
  logic [3:0]    o_bus_sel;
  logic [31:0]   i_bus_rdt;

  modport master (
    output i_start, i_op, i_size, i_signed, i_lsb, i_shamt, i_d, i_bus_ack, i_bus_rdt,
    input  o_q, o_q_vld, o_busy, o_done, o_misalign, o_bus_cyc, o_bus_dat, o_bus_sel
  );

  modport slave (
    input  i_start, i_op, i_size, i_signed, i_lsb, i_shamt, i_d, i_bus_ack, i_bus_rdt,
    output o_q, o_q_vld, o_busy, o_done, o_misalign, o_bus_cyc, o_bus_dat, o_bus_sel
  );
endinterface

// File: rtl/qerv_lsbuf_align.sv
// Byte-lane alignment: store replication/strobes and load shift/extension.
module qerv_lsbuf_align
  import qerv_lsbuf_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  lsb,
  input  logic [31:0] st_dat,
  input  logic [31:0] rdt,
  output logic [31:0] bus_dat,
  output logic [3:0]  bus_sel,
  output logic [31:0] ld_dat
);
  logic [31:0] rdt_sh;

  always_comb begin
    rdt_sh  = rdt >> {lsb, 3'b000};
    bus_dat = st_dat;
    bus_sel = 4'b1111;
    ld_dat  = rdt_sh;
    case (size_e'(size))
      SZ_BYTE: begin
        bus_dat = {4{st_dat[7:0]}};
        bus_sel = 4'b0001 << lsb;
        ld_dat  = {{24{sgn & rdt_sh[7]}}, rdt_sh[7:0]};
      end
      SZ_HALF: begin
        bus_dat = {2{st_dat[15:0]}};
        bus_sel = 4'b0011 << lsb;
        ld_dat  = {{16{sgn & rdt_sh[15]}}, rdt_sh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/qerv_lsbuf.sv
// Serial load/store/shift buffer: W bits per beat in and out of a 32-bit word.
// state    | meaning
// IDLE     | waiting for i_start; misaligned accesses finish here
// INIT     | N beats shifting i_d into the data register
// BUS      | bus request held until i_bus_ack
// SHIFT    | shift by W per cycle, then the remainder
// DRAIN    | N beats presenting data[W-1:0] on o_q
module qerv_lsbuf
  import qerv_lsbuf_pkg::*;
#(
  parameter int W = 1
) (
  input logic         i_clk,
  input logic         i_rst_n,
  qerv_lsbuf_if.slave io
);
  localparam int LB = $clog2(W);
  localparam int N  = 32 / W;
  localparam logic [4:0] CNT_LAST = 5'(N - 1);
  localparam logic [4:0] W5       = 5'(W);

  state_e      state;
  op_e         op_r;
  logic [1:0]  size_r;
  logic [1:0]  lsb_r;
  logic        sgn_r;
  logic [4:0]  shamt_r;
  logic [4:0]  cnt;
  logic [31:0] data;
  logic        bus_cyc;
  logic        done;
  logic        misalign;
  logic        q_vld;

  logic [31:0] st_bus_dat;
  logic [3:0]  st_bus_sel;
  logic [31:0] ld_dat;
  logic [4:0]  step;
  logic [4:0]  cnt_rem;
  logic        fill;
  logic signed [32:0] shr_ext;
  logic [31:0] shifted;

  qerv_lsbuf_align u_align (
    .size    (size_r),
    .sgn     (sgn_r),
    .lsb     (lsb_r),
    .st_dat  (data),
    .rdt     (io.i_bus_rdt),
    .bus_dat (st_bus_dat),
    .bus_sel (st_bus_sel),
    .ld_dat  (ld_dat)
  );

  // Full W-bit steps while count >= W, then one step of the leftover.
  always_comb begin
    step    = ((cnt >> LB) != 5'd0) ? W5 : cnt;
    cnt_rem = cnt - step;
    fill    = (op_r == OP_SHR) && sgn_r && data[31];
    shr_ext = $signed({fill, data}) >>> step;
    shifted = (op_r == OP_SHL) ? (data << step) : shr_ext[31:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      op_r     <= OP_STORE;
      size_r   <= 2'b00;
      lsb_r    <= 2'b00;
      sgn_r    <= 1'b0;
      shamt_r  <= 5'd0;
      cnt      <= 5'd0;
      data     <= 32'd0;
      bus_cyc  <= 1'b0;
      done     <= 1'b0;
      misalign <= 1'b0;
      q_vld    <= 1'b0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (io.i_start) begin
            op_r    <= op_e'(io.i_op);
            size_r  <= io.i_size;
            lsb_r   <= io.i_lsb;
            sgn_r   <= io.i_signed;
            shamt_r <= io.i_shamt;
            if (!io.i_op[1] && is_misaligned(io.i_size, io.i_lsb)) begin
              done     <= 1'b1;
              misalign <= 1'b1;
            end else if (op_e'(io.i_op) == OP_LOAD) begin
              state   <= ST_BUS;
              bus_cyc <= 1'b1;
            end else begin
              state <= ST_INIT;
              cnt   <= CNT_LAST;
            end
          end
        end
        ST_INIT: begin
          data <= {io.i_d, data[31:W]};
          if (cnt == 5'd0) begin
            if (op_r == OP_STORE) begin
              state   <= ST_BUS;
              bus_cyc <= 1'b1;
            end else if (shamt_r != 5'd0) begin
              state <= ST_SHIFT;
              cnt   <= shamt_r;
            end else begin
              state <= ST_DRAIN;
              cnt   <= CNT_LAST;
              q_vld <= 1'b1;
            end
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        ST_SHIFT: begin
          data <= shifted;
          if (cnt_rem == 5'd0) begin
            state <= ST_DRAIN;
            cnt   <= CNT_LAST;
            q_vld <= 1'b1;
          end else begin
            cnt <= cnt_rem;
          end
        end
        ST_BUS: begin
          if (io.i_bus_ack) begin
            bus_cyc <= 1'b0;
            if (op_r == OP_LOAD) begin
              data  <= ld_dat;
              state <= ST_DRAIN;
              cnt   <= CNT_LAST;
              q_vld <= 1'b1;
            end else begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          data <= data >> W;
          if (cnt == 5'd1) done <= 1'b1;
          if (cnt == 5'd0) begin
            state <= ST_IDLE;
            q_vld <= 1'b0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io.o_q        = q_vld ? data[W-1:0] : '0;
  assign io.o_q_vld    = q_vld;
  assign io.o_busy     = (state != ST_IDLE);
  assign io.o_done     = done;
  assign io.o_misalign = misalign;
  assign io.o_bus_cyc  = bus_cyc;
  assign io.o_bus_dat  = st_bus_dat;
  assign io.o_bus_sel  = bus_cyc ? st_bus_sel : 4'b0000;

endmodule

// File: doc/qerv_lsbuf.md
QERV_LSBUF -- requirements
Module: qerv_lsbuf

Interface
REQ-001 SHALL have parameter W, default 1; bits transferred per cycle; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have derived localparam LB = $clog2(W) and localparam N = 32/W, the beats per 32-bit word.
REQ-003 SHALL use one clock and an asynchronous active-low reset: i_clk in 1, rising-edge clock; i_rst_n in 1, async active-low reset.
REQ-004 Port i_start  in  1  starts an operation; sampled only in IDLE.
REQ-005 Port i_op  in  2  selects the operation: 00 store, 01 load, 10 shift-left, 11 shift-right.
REQ-006 Port i_size  in  2  selects the access size: 00 byte, 01 half, 10 word; 11 SHALL be treated as word.
REQ-007 Port i_signed  in  1  selects sign-extending load or arithmetic right shift.
REQ-008 Port i_lsb  in  2  gives the address low bits; i_shamt  in  5  gives the shift amount; both are sampled with i_start.
REQ-009 Port i_d  in  W  is the serial operand, LSB-first, one W-bit slice per INIT beat.
REQ-010 Port o_q  out  W  is the serial result, LSB-first; o_q_vld  out  1  is high in DRAIN.
REQ-011 Port o_busy  out  1  is high whenever the state is not IDLE.
REQ-012 Port o_done  out  1  is a one-cycle completion pulse.
REQ-013 Port o_misalign  out  1  is qualified by o_done.
REQ-014 Bus ports: o_bus_cyc  out  1  request; i_bus_ack  in  1  acknowledge; o_bus_dat  out  32  write data; o_bus_sel  out  4  byte strobes; i_bus_rdt  in  32  read data.

Function
REQ-015 The FSM SHALL have states IDLE, INIT, BUS, SHIFT and DRAIN, held in a 32-bit data register plus a 5-bit counter.
REQ-016 On i_start in IDLE, a misaligned access SHALL skip all other states: o_done=1 and o_misalign=1 the next cycle, no o_bus_cyc, then IDLE. Misaligned means half with i_lsb[0]=1, or word with i_lsb!=0.
REQ-017 In IDLE, i_start with a load SHALL go to BUS; a store or shift SHALL go to INIT.
REQ-018 INIT SHALL last exactly N cycles; each cycle shifts i_d into data[31:32-W] with the register moving right by W.
REQ-019 After INIT, a store SHALL go to BUS.
REQ-020 After INIT, a shift SHALL go to SHIFT if i_shamt!=0, else to DRAIN.
REQ-021 In SHIFT, each cycle SHALL shift data by W while the remaining count is >= W, then shift once by (count mod W) if nonzero. Total SHIFT cycles = floor(shamt/W) + (shamt mod W != 0).
REQ-022 SHIFT SHALL fill vacated bits with zero for left shifts, and for right shifts with data[31] if i_signed, else zero.
REQ-023 In BUS, o_bus_cyc SHALL be 1 and o_bus_dat/o_bus_sel SHALL stay stable until i_bus_ack; o_bus_cyc SHALL drop in the cycle after ack.
REQ-024 Store data: byte SHALL be replicated x4, half x2, word passed through.
REQ-025 Store strobes: byte SHALL be 0001<<i_lsb, half 0011<<i_lsb, word 1111.
REQ-026 Load: on ack, data SHALL capture i_bus_rdt shifted right by 8*i_lsb, then zero- or sign-extended from bit 7/15 per i_size/i_signed.
REQ-027 A load SHALL go to DRAIN the cycle after ack.
REQ-028 A store SHALL assert o_done in the cycle after ack, then go to IDLE.
REQ-029 DRAIN SHALL last exactly N cycles, presenting data[W-1:0] on o_q and shifting right by W each cycle.
REQ-030 o_done SHALL assert in the last DRAIN cycle.
REQ-031 o_q SHALL be 0 outside DRAIN.
REQ-032 i_start while o_busy=1 SHALL be ignored; a new operation SHALL be accepted no earlier than the cycle after o_done.
REQ-033 i_bus_ack outside BUS SHALL be ignored.
REQ-034 i_bus_ack in the first BUS cycle SHALL be accepted; zero-wait ack is legal.
REQ-035 o_bus_cyc, o_done and o_q_vld SHALL be driven from registered state only, with no combinational path from inputs.

Reset
REQ-036 Asserting i_rst_n=0 SHALL force IDLE immediately and asynchronously, including mid-operation and mid-BUS, where o_bus_cyc drops without waiting for ack.
REQ-037 Reset values SHALL be: o_busy=0, o_done=0, o_misalign=0, o_bus_cyc=0, o_bus_sel=0, o_q_vld=0, o_q=0, counter=0.
REQ-038 The data register SHALL reset to 0 so that o_bus_dat=0.
REQ-039 Release of reset SHALL be synchronous to i_clk.
REQ-040 The first i_start SHALL be accepted on the first rising edge after release.

Structure
REQ-041 A shared package qerv_lsbuf_pkg SHALL hold the op, size and state encodings.
REQ-042 One combinational sub-module, qerv_lsbuf_align, SHALL own the lane alignment: store replication/strobes and load shift/extension.

Verification
REQ-043 W=4 store byte: i_lsb=2, i_d slices LSB-first of word 0x000000A5, ack after 3 cycles -> o_bus_dat=0xA5A5A5A5, o_bus_sel=0100, o_done the cycle after ack, with INIT lasting exactly 8 cycles.
REQ-044 W=1 signed byte load: i_lsb=3, i_bus_rdt=0x80FF0000 -> o_q streams 0xFFFFFF80 over 32 cycles, o_done on cycle 32.
REQ-045 W=4 arithmetic right shift: operand 0x80000010, i_shamt=7, i_signed=1 -> 2 SHIFT cycles, then DRAIN result 0xFF000000.
REQ-046 W=8 shift-left, i_shamt=0: operand 0x12345678 -> no SHIFT state, DRAIN 0x12345678.
REQ-047 Misaligned half (i_lsb=1), any W -> o_done=1 and o_misalign=1 the next cycle, o_bus_cyc never 1.
REQ-048 Reset mid-BUS: assert i_rst_n=0 with o_bus_cyc=1 -> o_bus_cyc=0 within the same cycle; a subsequent store completes normally.
